// File: rtl/mole_ctrl.sv
// Mole sequencer: raises one pseudo-random mole at a time and times the gap/up/flash phases from the difficulty.
// Latency: all outputs registered; a whack sampled at edge k gives its pulse in cycle k+1 and drops the LED on edge k.
// Backpressure: none; whack pulses are consumed on arrival and ignored outside UP or while disabled.
module mole_ctrl #(
    parameter int          TICK_DIV  = 100000,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable_mole_ctrl,
    input  logic [1:0] difficulty_level,
    input  logic [7:0] whack_pulse,
    output logic [7:0] mole_leds,
    output logic [2:0] active_hole,
    output logic       hit_pulse,
    output logic       wrong_pulse,
    output logic       escape_pulse
);

    localparam int PW = $clog2(TICK_DIV);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GAP,
        ST_UP,
        ST_FLASH
    } state_t;

    // Phase lengths in milliseconds, indexed by the latched difficulty.
    function automatic logic [9:0] up_ms(input logic [1:0] d);
        case (d)
            2'd0:    return 10'd1000;
            2'd1:    return 10'd700;
            default: return 10'd450;
        endcase
    endfunction

    function automatic logic [9:0] gap_ms(input logic [1:0] d);
        case (d)
            2'd0:    return 10'd400;
            2'd1:    return 10'd300;
            default: return 10'd200;
        endcase
    endfunction

    localparam logic [9:0] FLASH_MS = 10'd150;

    state_t        state_q, state_d;
    logic [1:0]    diff_q, diff_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [9:0]    ms_q, ms_d;
    logic [15:0]   lfsr_q, lfsr_d;
    logic [7:0]    leds_q, leds_d;
    logic [2:0]    hole_q, hole_d;
    logic          hit_q, hit_d;
    logic          wrong_q, wrong_d;
    logic          esc_q, esc_d;

    logic          ms_tick;
    logic [9:0]    dur_ms;
    logic          expired;
    logic [1:0]    level;
    logic [2:0]    cand;
    logic [2:0]    pick;
    logic [7:0]    other_mask;
    logic          restart;

    // Free-running Galois LFSR, x^16+x^14+x^13+x^11, shifted right.
    always_comb begin
        lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    end

    // Phase timing: ms tick from the prescaler, duration of the current phase, and its expiry.
    // The ms counter saturates one past the last tick so an expiry deferred by a wrong whack
    // is still seen on the following cycle.
    always_comb begin
        ms_tick = (presc_q == PW'(TICK_DIV - 1));
        case (state_q)
            ST_GAP:   dur_ms = gap_ms(diff_q);
            ST_UP:    dur_ms = up_ms(diff_q);
            ST_FLASH: dur_ms = FLASH_MS;
            default:  dur_ms = 10'd0;
        endcase
        expired = (ms_q == dur_ms) || (ms_tick && (ms_q == dur_ms - 10'd1));
    end

    // Difficulty 3 behaves as hard; next hole avoids repeating the previous one.
    always_comb begin
        level      = (difficulty_level == 2'd3) ? 2'd2 : difficulty_level;
        cand       = lfsr_q[2:0];
        pick       = (cand == hole_q) ? cand + 3'd1 : cand;
        other_mask = ~(8'd1 << hole_q);
    end

    // Next state, LED and event logic; a low enable overrides everything and suppresses events.
    always_comb begin
        state_d = state_q;
        diff_d  = diff_q;
        leds_d  = leds_q;
        hole_d  = hole_q;
        hit_d   = 1'b0;
        wrong_d = 1'b0;
        esc_d   = 1'b0;
        if (!enable_mole_ctrl) begin
            state_d = ST_IDLE;
            leds_d  = 8'h00;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_GAP;
                    diff_d  = level;
                    leds_d  = 8'h00;
                end
                ST_GAP: begin
                    if (expired) begin
                        state_d = ST_UP;
                        hole_d  = pick;
                        leds_d  = 8'd1 << pick;
                    end
                end
                ST_UP: begin
                    if (whack_pulse[hole_q]) begin
                        hit_d   = 1'b1;
                        state_d = ST_FLASH;
                        leds_d  = 8'h00;
                    end else if (|(whack_pulse & other_mask)) begin
                        wrong_d = 1'b1;
                    end else if (expired) begin
                        esc_d   = 1'b1;
                        state_d = ST_GAP;
                        diff_d  = level;
                        leds_d  = 8'h00;
                    end
                end
                ST_FLASH: begin
                    leds_d = 8'h00;
                    if (expired) begin
                        state_d = ST_GAP;
                        diff_d  = level;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    leds_d  = 8'h00;
                end
            endcase
        end
    end

    // Counters restart on every state change and stay cleared while idle.
    always_comb begin
        restart = (state_d != state_q) || (state_q == ST_IDLE);
        presc_d = presc_q;
        ms_d    = ms_q;
        if (restart) begin
            presc_d = '0;
            ms_d    = 10'd0;
        end else if (ms_tick) begin
            presc_d = '0;
            if (ms_q != 10'h3FF) begin
                ms_d = ms_q + 10'd1;
            end
        end else begin
            presc_d = presc_q + PW'(1);
        end
    end

    // State, difficulty and timing registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            diff_q  <= 2'd0;
            presc_q <= '0;
            ms_q    <= 10'd0;
            lfsr_q  <= LFSR_SEED;
        end else begin
            state_q <= state_d;
            diff_q  <= diff_d;
            presc_q <= presc_d;
            ms_q    <= ms_d;
            lfsr_q  <= lfsr_d;
        end
    end

    // Registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            leds_q  <= 8'h00;
            hole_q  <= 3'd0;
            hit_q   <= 1'b0;
            wrong_q <= 1'b0;
            esc_q   <= 1'b0;
        end else begin
            leds_q  <= leds_d;
            hole_q  <= hole_d;
            hit_q   <= hit_d;
            wrong_q <= wrong_d;
            esc_q   <= esc_d;
        end
    end

    assign mole_leds    = leds_q;
    assign active_hole  = hole_q;
    assign hit_pulse    = hit_q;
    assign wrong_pulse  = wrong_q;
    assign escape_pulse = esc_q;

endmodule

// File: tb/tb_mole_ctrl.sv
// Directed bench for mole_ctrl with TICK_DIV=4: phase timing, whack classification, enable handling.
// Inputs are driven and outputs sampled on the falling clock edge.
// Hole choice is predicted from an independent model of the LFSR sequence.
`timescale 1ns/1ps
module tb_mole_ctrl;

    localparam int          TICK_DIV = 4;
    localparam logic [15:0] SEED     = 16'hACE1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       enable_mole_ctrl = 1'b0;
    logic [1:0] difficulty_level = 2'd0;
    logic [7:0] whack_pulse = 8'h00;
    logic [7:0] mole_leds;
    logic [2:0] active_hole;
    logic       hit_pulse;
    logic       wrong_pulse;
    logic       escape_pulse;

    int checks = 0;
    int passed = 0;
    int mole_count = 0;
    logic [2:0]  last_hole = 3'd0;
    logic [15:0] m_lfsr;
    logic [15:0] m_prev;

    mole_ctrl #(.TICK_DIV(TICK_DIV), .LFSR_SEED(SEED)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .enable_mole_ctrl (enable_mole_ctrl),
        .difficulty_level (difficulty_level),
        .whack_pulse      (whack_pulse),
        .mole_leds        (mole_leds),
        .active_hole      (active_hole),
        .hit_pulse        (hit_pulse),
        .wrong_pulse      (wrong_pulse),
        .escape_pulse     (escape_pulse)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        logic [15:0] r;
        r = {1'b0, s[15:1]};
        if (s[0]) r = r ^ 16'hB400;
        return r;
    endfunction

    // m_prev holds the LFSR value the DUT saw on the most recent edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_lfsr <= SEED;
            m_prev <= SEED;
        end else begin
            m_prev <= m_lfsr;
            m_lfsr <= lfsr_step(m_lfsr);
        end
    end

    task automatic wait_mole(input int budget, output int n);
        logic [2:0] exp_h;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (mole_leds === 8'h00 && n < budget);
        checks++;
        if (mole_leds === 8'h00) begin
            $display("FAIL mole_wait: no mole after %0d cycles", n);
            return;
        end
        passed++;
        exp_h = m_prev[2:0];
        if (exp_h == last_hole) exp_h = exp_h + 3'd1;
        checks++; if (active_hole !== exp_h) $display("FAIL mole_hole: active_hole=%0d want %0d", active_hole, exp_h); else passed++;
        checks++; if (mole_leds !== (8'd1 << exp_h)) $display("FAIL mole_leds: leds=%b want hole %0d", mole_leds, exp_h); else passed++;
        checks++; if (active_hole === last_hole) $display("FAIL mole_repeat: hole %0d equals previous %0d", active_hole, last_hole); else passed++;
        last_hole = exp_h;
        mole_count++;
    endtask

    task automatic wait_clear(input int budget, output int n, output int early);
        n = 0;
        early = 0;
        do begin
            @(negedge clk);
            n++;
            if (mole_leds !== 8'h00 && (hit_pulse || wrong_pulse || escape_pulse)) early++;
        end while (mole_leds !== 8'h00 && n < budget);
        checks++;
        if (mole_leds !== 8'h00) $display("FAIL clear_wait: leds=%b still on after %0d cycles", mole_leds, n); else passed++;
    endtask

    // Drop enable for one cycle while a mole is up (with a coinciding correct whack), then re-enable.
    task automatic disable_reenable();
        int n;
        logic [7:0] bit_v;
        bit_v = 8'd1 << last_hole;
        enable_mole_ctrl = 1'b0;
        whack_pulse = bit_v;
        @(negedge clk);
        whack_pulse = 8'h00;
        checks++; if (mole_leds !== 8'h00) $display("FAIL dis_leds: leds=%b want 00000000", mole_leds); else passed++;
        checks++; if ({hit_pulse, wrong_pulse, escape_pulse} !== 3'b000) $display("FAIL dis_pulses: hit/wrong/esc=%b want 000", {hit_pulse, wrong_pulse, escape_pulse}); else passed++;
        checks++; if (active_hole !== last_hole) $display("FAIL dis_hold: active_hole=%0d want %0d", active_hole, last_hole); else passed++;
        enable_mole_ctrl = 1'b1;
        wait_mole(2000, n);
        checks++; if (n != 801) $display("FAIL reen_gap: mole after %0d cycles want 801", n); else passed++;
    endtask

    // Precondition: a mole is up. Cycles moles until one sits on the target hole.
    task automatic find_hole(input logic [2:0] target);
        for (int i = 0; i < 40; i++) begin
            if (last_hole == target) return;
            disable_reenable();
        end
        checks++;
        if (last_hole !== target) $display("FAIL find_hole: last hole %0d want %0d", last_hole, target); else passed++;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #2;
        checks++; if (mole_leds !== 8'h00) $display("FAIL rst_leds: leds=%b want 00000000", mole_leds); else passed++;
        checks++; if (active_hole !== 3'd0) $display("FAIL rst_hole: active_hole=%0d want 0", active_hole); else passed++;
        checks++; if ({hit_pulse, wrong_pulse, escape_pulse} !== 3'b000) $display("FAIL rst_pulses: %b want 000", {hit_pulse, wrong_pulse, escape_pulse}); else passed++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        checks++; if (mole_leds !== 8'h00) $display("FAIL idle_leds: leds=%b want 00000000", mole_leds); else passed++;
    endtask

    task automatic test_escape();
        int n;
        int early;
        difficulty_level = 2'd0;
        enable_mole_ctrl = 1'b1;
        wait_mole(3000, n);
        checks++; if (n != 1601) $display("FAIL first_mole: after %0d cycles want 1601", n); else passed++;
        wait_clear(6000, n, early);
        checks++; if (n != 4000) $display("FAIL up_easy: %0d cycles want 4000", n); else passed++;
        checks++; if (early != 0) $display("FAIL up_quiet: %0d pulses while up want 0", early); else passed++;
        checks++; if ({hit_pulse, wrong_pulse, escape_pulse} !== 3'b001) $display("FAIL escape: hit/wrong/esc=%b want 001", {hit_pulse, wrong_pulse, escape_pulse}); else passed++;
        @(negedge clk);
        checks++; if (escape_pulse !== 1'b0) $display("FAIL escape_once: escape=%b want 0", escape_pulse); else passed++;
        wait_mole(3000, n);
        checks++; if (n != 1599) $display("FAIL gap_easy: mole after %0d more cycles want 1599", n); else passed++;
    endtask

    // Continues on the mole raised by test_escape.
    task automatic test_difficulty_change();
        int n;
        int early;
        difficulty_level = 2'd2;
        wait_clear(6000, n, early);
        checks++; if (n != 4000) $display("FAIL diff_keep_up: %0d cycles want 4000", n); else passed++;
        wait_mole(3000, n);
        checks++; if (n != 800) $display("FAIL diff_gap_hard: %0d cycles want 800", n); else passed++;
        wait_clear(6000, n, early);
        checks++; if (n != 1800) $display("FAIL diff_up_hard: %0d cycles want 1800", n); else passed++;
    endtask

    task automatic test_hit();
        int n;
        wait_mole(3000, n);
        find_hole(3'd5);
        whack_pulse = 8'b0010_0000;
        @(negedge clk);
        whack_pulse = 8'hFF;
        checks++; if ({hit_pulse, wrong_pulse, escape_pulse} !== 3'b100) $display("FAIL hit: hit/wrong/esc=%b want 100", {hit_pulse, wrong_pulse, escape_pulse}); else passed++;
        checks++; if (mole_leds !== 8'h00) $display("FAIL hit_leds: leds=%b want 00000000", mole_leds); else passed++;
        @(negedge clk);
        whack_pulse = 8'h00;
        checks++; if ({hit_pulse, wrong_pulse, escape_pulse} !== 3'b000) $display("FAIL flash_ignore: hit/wrong/esc=%b want 000", {hit_pulse, wrong_pulse, escape_pulse}); else passed++;
        wait_mole(3000, n);
        checks++; if (n != 1399) $display("FAIL flash_gap: mole after %0d cycles want 1399", n); else passed++;
    endtask

    // Continues with the mole left up by test_hit.
    task automatic test_wrong_and_same_cycle();
        find_hole(3'd5);
        whack_pulse = 8'b0000_0011;
        @(negedge clk);
        whack_pulse = 8'h00;
        checks++; if ({hit_pulse, wrong_pulse, escape_pulse} !== 3'b010) $display("FAIL wrong: hit/wrong/esc=%b want 010", {hit_pulse, wrong_pulse, escape_pulse}); else passed++;
        checks++; if (mole_leds !== 8'b0010_0000) $display("FAIL wrong_leds: leds=%b want 00100000", mole_leds); else passed++;
        @(negedge clk);
        checks++; if (wrong_pulse !== 1'b0) $display("FAIL wrong_single: wrong=%b want 0", wrong_pulse); else passed++;
        whack_pulse = 8'b0010_0011;
        @(negedge clk);
        whack_pulse = 8'h00;
        checks++; if ({hit_pulse, wrong_pulse, escape_pulse} !== 3'b100) $display("FAIL same_cycle: hit/wrong/esc=%b want 100", {hit_pulse, wrong_pulse, escape_pulse}); else passed++;
        checks++; if (mole_leds !== 8'h00) $display("FAIL same_leds: leds=%b want 00000000", mole_leds); else passed++;
    endtask

    task automatic test_timeout_hit();
        int n;
        logic [7:0] bit_v;
        wait_mole(3000, n);
        bit_v = 8'd1 << last_hole;
        repeat (1799) @(negedge clk);
        checks++; if (mole_leds !== bit_v) $display("FAIL to_still_up: leds=%b want %b", mole_leds, bit_v); else passed++;
        whack_pulse = bit_v;
        @(negedge clk);
        whack_pulse = 8'h00;
        checks++; if ({hit_pulse, wrong_pulse, escape_pulse} !== 3'b100) $display("FAIL to_hit: hit/wrong/esc=%b want 100", {hit_pulse, wrong_pulse, escape_pulse}); else passed++;
        checks++; if (mole_leds !== 8'h00) $display("FAIL to_leds: leds=%b want 00000000", mole_leds); else passed++;
        @(negedge clk);
        checks++; if ({hit_pulse, wrong_pulse, escape_pulse} !== 3'b000) $display("FAIL to_after: hit/wrong/esc=%b want 000", {hit_pulse, wrong_pulse, escape_pulse}); else passed++;
    endtask

    task automatic test_run64();
        int n;
        wait_mole(3000, n);
        for (int i = 0; i < 70 && mole_count < 64; i++) begin
            disable_reenable();
        end
        checks++; if (mole_count < 64) $display("FAIL run64: only %0d moles seen want 64", mole_count); else passed++;
    endtask

    // Precondition: a mole is up; reset is asserted between clock edges.
    task automatic test_async_reset();
        @(negedge clk);
        checks++; if (mole_leds === 8'h00) $display("FAIL ar_pre: leds=%b want a mole up", mole_leds); else passed++;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (mole_leds !== 8'h00) $display("FAIL ar_leds: leds=%b want 00000000", mole_leds); else passed++;
        checks++; if (active_hole !== 3'd0) $display("FAIL ar_hole: active_hole=%0d want 0", active_hole); else passed++;
        checks++; if ({hit_pulse, wrong_pulse, escape_pulse} !== 3'b000) $display("FAIL ar_pulses: %b want 000", {hit_pulse, wrong_pulse, escape_pulse}); else passed++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_escape();
        test_difficulty_change();
        test_hit();
        test_wrong_and_same_cycle();
        test_timeout_hit();
        test_run64();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
